parking_zone_controller: RTL and testbench
==========================================

PARKING_ZONE_CONTROLLER -- requirements
Module: parking_zone_controller

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NUM_CLASSES, 3: vehicle classes; class 0 is reserved, class NUM_CLASSES-1 is guest.
- CNT_W, 10: counter width.
- TOTAL_CAP, 700: lot capacity.
- RES_CAP, 500: reset cap of class 0.
- BASE_CAP, 200: reset cap of all other classes.
- PHASE_TICKS, 120: minute_tick pulses per phase.
- MAX_PHASE, 4: phase saturation value.
- PHASE_STEP, 50: guest cap increment per phase.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: clock.
- reset, in, 1: reset.
- minute_tick, in, 1: one-cycle time pulse.
- entry_valid, in, 1: entry request.
- entry_class, in, CLS_W = clog2(NUM_CLASSES): class of the entering vehicle.
- exit_valid, in, 1: exit request.
- exit_class, in, CLS_W: class of the exiting vehicle.
- cfg_we, in, 1: cap write strobe.
- cfg_class, in, CLS_W: class whose cap is written.
- cfg_cap, in, CNT_W: new cap value.
- entry_grant, out, 1: entry accepted.
- entry_deny, out, 1: entry refused.
- exit_ack, out, 1: exit accepted.
- exit_err, out, 1: exit refused.
- occ_bus, out, NUM_CLASSES*CNT_W: per-class occupancy.
- free_bus, out, NUM_CLASSES*CNT_W: per-class free slots.
- avail, out, NUM_CLASSES: per-class space-available flag.
- total_occ, out, CNT_W: total occupancy.
- lot_full, out, 1: lot at capacity.
- phase, out, 3: current time phase.
- deny_cnt_bus, out, NUM_CLASSES*16: per-class denial counts.
REQ-003 The block SHALL use a single clock clk; reset SHALL be synchronous and active-high.

Function
REQ-004 Effective cap per class SHALL be computed at CNT_W+1 bits and clamped to TOTAL_CAP: cap_reg[c], plus phase*PHASE_STEP for the guest class only.
REQ-005 An entry SHALL be granted iff all hold against pre-edge state: class index < NUM_CLASSES, occ[c] < effective cap[c], total_occ < TOTAL_CAP.
REQ-006 entry_grant/entry_deny SHALL pulse one cycle after entry_valid; occ[c] and total_occ SHALL increment on the same edge that raises entry_grant.
REQ-007 An exit SHALL be accepted iff class index is valid and occ[c] > 0; exit_ack pulses next cycle and the counts decrement. Otherwise exit_err pulses and nothing changes.
REQ-008 Simultaneous entry and exit SHALL both be processed in one cycle:
- The entry decision uses pre-edge counts.
- Same-class entry and exit with both accepted leaves occ[c] and total_occ unchanged.
REQ-009 Counters SHALL never wrap; the REQ-005/REQ-007 guards guarantee this.
REQ-010 free_bus[c] SHALL equal effective cap[c] minus occ[c], floored at 0.
REQ-011 avail[c] SHALL equal (free[c] != 0) && !lot_full, where lot_full = (total_occ == TOTAL_CAP); all three are combinational from registered state.
REQ-012 Cap writes:
- cfg_we SHALL load cfg_cap into cap_reg[cfg_class] at the next edge; an invalid class is ignored.
- A cap below current occupancy SHALL evict nothing; avail stays 0 until occupancy falls below the cap.
- An entry evaluated in the same cycle as cfg_we SHALL use the old cap.
REQ-013 Phase scheduler:
- A tick counter SHALL count minute_tick pulses 0..PHASE_TICKS-1.
- On the tick at PHASE_TICKS-1 the counter clears and phase increments, saturating at MAX_PHASE.
- Once phase = MAX_PHASE, the counter SHALL hold at 0.
REQ-014 Outputs other than combinational flags SHALL be registered; no output SHALL depend combinationally on request inputs.

Reset
REQ-015 On reset all of the following SHALL hold, and an in-flight request SHALL be dropped without a response:
- occ, total_occ, phase, tick counter, deny counts: 0.
- Pulse outputs: 0.
- cap_reg[0] = RES_CAP; other cap_reg = BASE_CAP.
- Hence avail = all ones and lot_full = 0.

Configuration
REQ-016 With PARKING_DENY_STATS_EN defined:
- deny_cnt_bus[c] SHALL increment on each entry_deny for a valid class c, saturating at 16'hFFFF.
- Denials for an invalid class index SHALL not be counted.
REQ-017 Without PARKING_DENY_STATS_EN, deny_cnt_bus SHALL be present and tied to 0, and no counter flops SHALL be inferred.

Verification (defaults)
REQ-018 Fill test:
- Stimulus: 200 guest entries, then 1 more.
- Required: 200 grants; the 201st is denied; avail[2]=0; free[2]=0.
REQ-019 Phase test:
- Stimulus: from the REQ-018 state, 120 minute_ticks.
- Required: phase=1; guest effective cap 250; free[2]=50; the next guest entry is granted.
REQ-020 Lot-full test:
- Stimulus: 500 class-0 entries, 200 class-1 entries, then an entry of any class.
- Required: total_occ=700; lot_full=1; the entry is denied; avail=0.
REQ-021 Concurrent same-class test:
- Stimulus: occ[1]=5; same-cycle class-1 entry and exit.
- Required: grant and ack both pulse; occ[1]=5.
- Stimulus: exit on class 0 with occ[0]=0.
- Required: exit_err pulses.
REQ-022 Cap lowered below occupancy:
- Stimulus: occ[1]=50, then cfg write of cap 40 to class 1.
- Required: free[1]=0; entries denied; after 11 exits avail[1]=1.
REQ-023 Stats and reset:
- Stimulus: with PARKING_DENY_STATS_EN, 3 denied class-2 entries.
- Required: deny_cnt[2]=3.
- Stimulus: reset mid-request.
- Required: all counts 0; no grant pulse follows.

Source files
------------

// File: rtl/parking_zone_controller.sv
// Parking zone controller: per-class occupancy and caps, with a time-phased guest cap boost.
// Optional per-class denial counters are built when PARKING_DENY_STATS_EN is defined.
module parking_zone_controller #(
   parameter int unsigned NUM_CLASSES = 3,
   parameter int unsigned CNT_W       = 10,
   parameter int unsigned TOTAL_CAP   = 700,
   parameter int unsigned RES_CAP     = 500,
   parameter int unsigned BASE_CAP    = 200,
   parameter int unsigned PHASE_TICKS = 120,
   parameter int unsigned MAX_PHASE   = 4,
   parameter int unsigned PHASE_STEP  = 50,
   localparam int unsigned CLS_W      = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         minute_tick,
   input  logic                         entry_valid,
   input  logic [CLS_W-1:0]             entry_class,
   input  logic                         exit_valid,
   input  logic [CLS_W-1:0]             exit_class,
   input  logic                         cfg_we,
   input  logic [CLS_W-1:0]             cfg_class,
   input  logic [CNT_W-1:0]             cfg_cap,
   output logic                         entry_grant,
   output logic                         entry_deny,
   output logic                         exit_ack,
   output logic                         exit_err,
   output logic [NUM_CLASSES*CNT_W-1:0] occ_bus,
   output logic [NUM_CLASSES*CNT_W-1:0] free_bus,
   output logic [NUM_CLASSES-1:0]       avail,
   output logic [CNT_W-1:0]             total_occ,
   output logic                         lot_full,
   output logic [2:0]                   phase,
   output logic [NUM_CLASSES*16-1:0]    deny_cnt_bus
);

   localparam int unsigned GUEST = NUM_CLASSES - 1;
   localparam int unsigned TICK_W = (PHASE_TICKS > 1) ? $clog2(PHASE_TICKS) : 1;
   localparam logic [CNT_W:0] TOTAL_W = (CNT_W + 1)'(TOTAL_CAP);
   localparam logic [CNT_W-1:0] TOTAL_N = CNT_W'(TOTAL_CAP);

   logic [CNT_W-1:0]   occ_q [NUM_CLASSES];
   logic [CNT_W-1:0]   cap_q [NUM_CLASSES];
   logic [CNT_W:0]     eff_wide [NUM_CLASSES];
   logic [CNT_W-1:0]   eff [NUM_CLASSES];
   logic [CNT_W-1:0]   free [NUM_CLASSES];
   logic [CNT_W-1:0]   total_q;
   logic [2:0]         phase_q;
   logic [TICK_W-1:0]  tick_q;
   logic               grant_q, deny_q, ack_q, err_q;
   logic [NUM_CLASSES-1:0] ent_hit, ext_hit, room, has_occ;
   logic               grant_ok, exit_ok, lot_full_w;
   logic [CNT_W:0]     guest_add;

   assign guest_add  = (CNT_W + 1)'(phase_q) * (CNT_W + 1)'(PHASE_STEP);
   assign lot_full_w = (total_q == TOTAL_N);

   // Class decode by comparison so an out-of-range index simply matches no class.
   always_comb begin
      for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
         eff_wide[c] = {1'b0, cap_q[c]} + ((c == GUEST) ? guest_add : '0);
         eff[c]      = (eff_wide[c] > TOTAL_W) ? TOTAL_N : eff_wide[c][CNT_W-1:0];
         free[c]     = (eff[c] > occ_q[c]) ? (eff[c] - occ_q[c]) : '0;
         ent_hit[c]  = entry_valid && (entry_class == CLS_W'(c));
         ext_hit[c]  = exit_valid && (exit_class == CLS_W'(c));
         room[c]     = (occ_q[c] < eff[c]);
         has_occ[c]  = (occ_q[c] != '0);
         avail[c]    = (free[c] != '0) && !lot_full_w;
         occ_bus[c*CNT_W +: CNT_W]  = occ_q[c];
         free_bus[c*CNT_W +: CNT_W] = free[c];
      end
   end

   assign grant_ok = (|(ent_hit & room)) && (total_q < TOTAL_N);
   assign exit_ok  = |(ext_hit & has_occ);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
            occ_q[c] <= '0;
            cap_q[c] <= (c == 0) ? CNT_W'(RES_CAP) : CNT_W'(BASE_CAP);
         end
         total_q <= '0;
         phase_q <= '0;
         tick_q  <= '0;
         grant_q <= 1'b0;
         deny_q  <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         grant_q <= grant_ok;
         deny_q  <= entry_valid && !grant_ok;
         ack_q   <= exit_ok;
         err_q   <= exit_valid && !exit_ok;
         for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
            occ_q[c] <= occ_q[c] + CNT_W'(ent_hit[c] && grant_ok)
                                 - CNT_W'(ext_hit[c] && exit_ok);
            if (cfg_we && (cfg_class == CLS_W'(c))) begin
               cap_q[c] <= cfg_cap;
            end
         end
         total_q <= total_q + CNT_W'(grant_ok) - CNT_W'(exit_ok);
         // Once saturated the tick counter stays parked at zero.
         if (minute_tick && (phase_q < 3'(MAX_PHASE))) begin
            if (tick_q == TICK_W'(PHASE_TICKS - 1)) begin
               tick_q  <= '0;
               phase_q <= phase_q + 3'd1;
            end else begin
               tick_q <= tick_q + TICK_W'(1);
            end
         end
      end
   end

   assign entry_grant = grant_q;
   assign entry_deny  = deny_q;
   assign exit_ack    = ack_q;
   assign exit_err    = err_q;
   assign total_occ   = total_q;
   assign lot_full    = lot_full_w;
   assign phase       = phase_q;

`ifdef PARKING_DENY_STATS_EN
   logic [15:0] deny_cnt_q [NUM_CLASSES];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
            deny_cnt_q[c] <= '0;
         end
      end else begin
         for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
            if (ent_hit[c] && !grant_ok && (deny_cnt_q[c] != 16'hFFFF)) begin
               deny_cnt_q[c] <= deny_cnt_q[c] + 16'd1;
            end
         end
      end
   end

   always_comb begin
      for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
         deny_cnt_bus[c*16 +: 16] = deny_cnt_q[c];
      end
   end
`else
   assign deny_cnt_bus = '0;
`endif

endmodule

// File: tb/tb_parking_zone_controller.sv
// Bench for parking_zone_controller: directed scenarios plus randomized traffic
// checked against a counting model of lot occupancy, caps and phases.
module tb_parking_zone_controller;

   localparam int NC = 3, CW = 10, TOTAL = 700, RES = 500, BASE = 200;
   localparam int PT = 120, MAXP = 4, STEP = 50;
`ifdef PARKING_DENY_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clk, reset, minute_tick, entry_valid, exit_valid, cfg_we;
   logic [1:0] entry_class, exit_class, cfg_class;
   logic [9:0] cfg_cap;
   logic entry_grant, entry_deny, exit_ack, exit_err, lot_full;
   logic [29:0] occ_bus, free_bus;
   logic [2:0] avail, phase;
   logic [9:0] total_occ;
   logic [47:0] deny_cnt_bus;

   int checks = 0;
   int passes = 0;

   int m_occ [NC];
   int m_cap [NC];
   int m_deny [NC];
   int m_phase, m_tick;
   bit e_grant, e_deny, e_ack, e_err;

   parking_zone_controller #(
      .NUM_CLASSES(NC), .CNT_W(CW), .TOTAL_CAP(TOTAL), .RES_CAP(RES), .BASE_CAP(BASE),
      .PHASE_TICKS(PT), .MAX_PHASE(MAXP), .PHASE_STEP(STEP)
   ) dut (
      .clk(clk), .reset(reset), .minute_tick(minute_tick),
      .entry_valid(entry_valid), .entry_class(entry_class),
      .exit_valid(exit_valid), .exit_class(exit_class),
      .cfg_we(cfg_we), .cfg_class(cfg_class), .cfg_cap(cfg_cap),
      .entry_grant(entry_grant), .entry_deny(entry_deny),
      .exit_ack(exit_ack), .exit_err(exit_err),
      .occ_bus(occ_bus), .free_bus(free_bus), .avail(avail),
      .total_occ(total_occ), .lot_full(lot_full), .phase(phase),
      .deny_cnt_bus(deny_cnt_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int m_eff(int c);
      int v;
      v = m_cap[c] + ((c == NC - 1) ? m_phase * STEP : 0);
      return (v > TOTAL) ? TOTAL : v;
   endfunction

   function automatic int m_total();
      return m_occ[0] + m_occ[1] + m_occ[2];
   endfunction

   function automatic int m_free(int c);
      int f;
      f = m_eff(c) - m_occ[c];
      return (f < 0) ? 0 : f;
   endfunction

   function automatic logic [29:0] exp_occ_bus();
      logic [29:0] r;
      for (int c = 0; c < NC; c++) r[c*10 +: 10] = 10'(m_occ[c]);
      return r;
   endfunction

   function automatic logic [29:0] exp_free_bus();
      logic [29:0] r;
      for (int c = 0; c < NC; c++) r[c*10 +: 10] = 10'(m_free(c));
      return r;
   endfunction

   function automatic logic [2:0] exp_avail();
      logic [2:0] r;
      for (int c = 0; c < NC; c++) r[c] = (m_free(c) != 0) && (m_total() != TOTAL);
      return r;
   endfunction

   function automatic logic [47:0] exp_deny_bus();
      logic [47:0] r;
      for (int c = 0; c < NC; c++) r[c*16 +: 16] = STATS ? 16'(m_deny[c]) : 16'd0;
      return r;
   endfunction

   task automatic idle_inputs();
      minute_tick = 0; entry_valid = 0; exit_valid = 0; cfg_we = 0;
      entry_class = 0; exit_class = 0; cfg_class = 0; cfg_cap = 0;
   endtask

   task automatic model_reset();
      for (int c = 0; c < NC; c++) begin
         m_occ[c] = 0;
         m_deny[c] = 0;
         m_cap[c] = (c == 0) ? RES : BASE;
      end
      m_phase = 0; m_tick = 0;
      e_grant = 0; e_deny = 0; e_ack = 0; e_err = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 0;
      model_reset();
   endtask

   // One clock of stimulus; the model advances alongside and inputs return to idle.
   task automatic cycle(input bit ev, input int ec, input bit xv, input int xc,
                        input bit we, input int wc, input int wcap, input bit tk);
      bit g, a;
      entry_valid = ev; entry_class = 2'(ec);
      exit_valid = xv; exit_class = 2'(xc);
      cfg_we = we; cfg_class = 2'(wc); cfg_cap = 10'(wcap);
      minute_tick = tk;
      g = ev && (ec < NC) && (m_occ[ec] < m_eff(ec)) && (m_total() < TOTAL);
      a = xv && (xc < NC) && (m_occ[xc] > 0);
      e_grant = g; e_deny = ev && !g; e_ack = a; e_err = xv && !a;
      if (ev && !g && (ec < NC) && (m_deny[ec] < 65535)) m_deny[ec]++;
      @(posedge clk);
      if (g) m_occ[ec]++;
      if (a) m_occ[xc]--;
      if (we && (wc < NC)) m_cap[wc] = wcap;
      if (tk && (m_phase < MAXP)) begin
         m_tick++;
         if (m_tick == PT) begin
            m_tick = 0;
            m_phase++;
         end
      end
      #1 idle_inputs();
   endtask

   task automatic enter(input int c);
      cycle(1, c, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic leave(input int c);
      cycle(0, 0, 1, c, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (occ_bus !== 30'd0) $display("FAIL reset_occ: got %0h want 0", occ_bus); else passes++;
      checks++; if (total_occ !== 10'd0) $display("FAIL reset_total: got %0d want 0", total_occ); else passes++;
      checks++; if (phase !== 3'd0) $display("FAIL reset_phase: got %0d want 0", phase); else passes++;
      checks++; if (avail !== 3'b111) $display("FAIL reset_avail: got %b want 111", avail); else passes++;
      checks++; if (lot_full !== 1'b0) $display("FAIL reset_lot_full: got %b want 0", lot_full); else passes++;
      checks++; if (free_bus !== {10'd200, 10'd200, 10'd500})
         $display("FAIL reset_free: got %0h want %0h", free_bus, {10'd200, 10'd200, 10'd500}); else passes++;
      checks++; if ({entry_grant, entry_deny, exit_ack, exit_err} !== 4'b0)
         $display("FAIL reset_pulses: got %b want 0000", {entry_grant, entry_deny, exit_ack, exit_err}); else passes++;
      checks++; if (deny_cnt_bus !== 48'd0) $display("FAIL reset_deny: got %0h want 0", deny_cnt_bus); else passes++;
   endtask

   task automatic test_fill();
      int ng = 0;
      do_reset();
      for (int i = 0; i < 200; i++) begin
         enter(2);
         if (entry_grant === 1'b1) ng++;
      end
      checks++; if (ng != 200) $display("FAIL fill_grants: got %0d want 200", ng); else passes++;
      enter(2);
      checks++; if ({entry_grant, entry_deny} !== 2'b01)
         $display("FAIL fill_201_deny: got grant/deny %b want 01", {entry_grant, entry_deny}); else passes++;
      checks++; if (avail[2] !== 1'b0) $display("FAIL fill_avail2: got %b want 0", avail[2]); else passes++;
      checks++; if (free_bus[29:20] !== 10'd0) $display("FAIL fill_free2: got %0d want 0", free_bus[29:20]); else passes++;
      checks++; if (occ_bus[29:20] !== 10'd200) $display("FAIL fill_occ2: got %0d want 200", occ_bus[29:20]); else passes++;
   endtask

   task automatic test_phase();
      for (int i = 0; i < 120; i++) cycle(0, 0, 0, 0, 0, 0, 0, 1);
      checks++; if (phase !== 3'd1) $display("FAIL phase_one: got %0d want 1", phase); else passes++;
      checks++; if (free_bus[29:20] !== 10'd50) $display("FAIL phase_free2: got %0d want 50", free_bus[29:20]); else passes++;
      enter(2);
      checks++; if (entry_grant !== 1'b1) $display("FAIL phase_grant: got %b want 1", entry_grant); else passes++;
      // Walk to one tick short of saturation, then across it, then well past it.
      for (int i = 0; i < 359; i++) cycle(0, 0, 0, 0, 0, 0, 0, 1);
      checks++; if (phase !== 3'd3) $display("FAIL phase_pre_sat: got %0d want 3", phase); else passes++;
      cycle(0, 0, 0, 0, 0, 0, 0, 1);
      checks++; if (phase !== 3'd4) $display("FAIL phase_sat: got %0d want 4", phase); else passes++;
      for (int i = 0; i < 200; i++) cycle(0, 0, 0, 0, 0, 0, 0, 1);
      checks++; if (phase !== 3'd4) $display("FAIL phase_hold: got %0d want 4", phase); else passes++;
      checks++; if (free_bus !== exp_free_bus())
         $display("FAIL phase_sat_free: got %0h want %0h", free_bus, exp_free_bus()); else passes++;
   endtask

   task automatic test_lot_full();
      int ng = 0;
      do_reset();
      for (int i = 0; i < 500; i++) begin
         enter(0);
         if (entry_grant === 1'b1) ng++;
      end
      for (int i = 0; i < 200; i++) begin
         enter(1);
         if (entry_grant === 1'b1) ng++;
      end
      checks++; if (ng != 700) $display("FAIL full_grants: got %0d want 700", ng); else passes++;
      enter(2);
      checks++; if ({entry_grant, entry_deny} !== 2'b01)
         $display("FAIL full_deny: got grant/deny %b want 01", {entry_grant, entry_deny}); else passes++;
      checks++; if (total_occ !== 10'd700) $display("FAIL full_total: got %0d want 700", total_occ); else passes++;
      checks++; if (lot_full !== 1'b1) $display("FAIL full_flag: got %b want 1", lot_full); else passes++;
      checks++; if (avail !== 3'b000) $display("FAIL full_avail: got %b want 000", avail); else passes++;
   endtask

   task automatic test_concurrent();
      do_reset();
      for (int i = 0; i < 5; i++) enter(1);
      cycle(1, 1, 1, 1, 0, 0, 0, 0);
      checks++; if ({entry_grant, exit_ack} !== 2'b11)
         $display("FAIL conc_pulses: got grant/ack %b want 11", {entry_grant, exit_ack}); else passes++;
      checks++; if (occ_bus[19:10] !== 10'd5) $display("FAIL conc_occ1: got %0d want 5", occ_bus[19:10]); else passes++;
      checks++; if (total_occ !== 10'd5) $display("FAIL conc_total: got %0d want 5", total_occ); else passes++;
      leave(0);
      checks++; if ({exit_ack, exit_err} !== 2'b01)
         $display("FAIL conc_exit_err: got ack/err %b want 01", {exit_ack, exit_err}); else passes++;
      checks++; if (occ_bus[9:0] !== 10'd0) $display("FAIL conc_occ0: got %0d want 0", occ_bus[9:0]); else passes++;
   endtask

   task automatic test_cap_lower();
      do_reset();
      for (int i = 0; i < 50; i++) enter(1);
      cycle(0, 0, 0, 0, 1, 1, 40, 0);
      checks++; if (free_bus[19:10] !== 10'd0) $display("FAIL caplow_free1: got %0d want 0", free_bus[19:10]); else passes++;
      checks++; if (occ_bus[19:10] !== 10'd50) $display("FAIL caplow_occ1: got %0d want 50", occ_bus[19:10]); else passes++;
      enter(1);
      checks++; if (entry_deny !== 1'b1) $display("FAIL caplow_deny: got %b want 1", entry_deny); else passes++;
      for (int i = 0; i < 10; i++) leave(1);
      checks++; if (avail[1] !== 1'b0) $display("FAIL caplow_avail_10: got %b want 0", avail[1]); else passes++;
      leave(1);
      checks++; if (avail[1] !== 1'b1) $display("FAIL caplow_avail_11: got %b want 1", avail[1]); else passes++;
      checks++; if (free_bus[19:10] !== 10'd1) $display("FAIL caplow_free_11: got %0d want 1", free_bus[19:10]); else passes++;
      // An entry in the same cycle as a cap write sees the old cap.
      do_reset();
      cycle(1, 0, 0, 0, 1, 0, 0, 0);
      checks++; if (entry_grant !== 1'b1) $display("FAIL cfg_old_cap: got %b want 1", entry_grant); else passes++;
      enter(0);
      checks++; if (entry_deny !== 1'b1) $display("FAIL cfg_new_cap: got %b want 1", entry_deny); else passes++;
   endtask

   task automatic test_stats();
      do_reset();
      cycle(0, 0, 0, 0, 1, 2, 0, 0);
      for (int i = 0; i < 3; i++) enter(2);
      enter(3);
      checks++; if (entry_deny !== 1'b1) $display("FAIL stats_bad_class_deny: got %b want 1", entry_deny); else passes++;
      checks++; if (deny_cnt_bus[47:32] !== (STATS ? 16'd3 : 16'd0))
         $display("FAIL stats_cnt2: got %0d want %0d", deny_cnt_bus[47:32], STATS ? 3 : 0); else passes++;
      checks++; if (deny_cnt_bus !== exp_deny_bus())
         $display("FAIL stats_bus: got %0h want %0h", deny_cnt_bus, exp_deny_bus()); else passes++;
      cycle(0, 0, 0, 0, 1, 3, 5, 0);
      checks++; if (free_bus !== exp_free_bus())
         $display("FAIL stats_bad_cfg: got %0h want %0h", free_bus, exp_free_bus()); else passes++;
      leave(3);
      checks++; if (exit_err !== 1'b1) $display("FAIL stats_bad_exit: got %b want 1", exit_err); else passes++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 3; i++) enter(0);
      cycle(0, 0, 0, 0, 1, 2, 0, 0);
      enter(2);
      entry_valid = 1; entry_class = 0; reset = 1;
      @(posedge clk);
      #1;
      checks++; if (entry_grant !== 1'b0) $display("FAIL rstmid_grant: got %b want 0", entry_grant); else passes++;
      @(posedge clk);
      #1 reset = 0;
      idle_inputs();
      model_reset();
      checks++; if (occ_bus !== 30'd0) $display("FAIL rstmid_occ: got %0h want 0", occ_bus); else passes++;
      checks++; if (total_occ !== 10'd0) $display("FAIL rstmid_total: got %0d want 0", total_occ); else passes++;
      checks++; if (deny_cnt_bus !== 48'd0) $display("FAIL rstmid_deny: got %0h want 0", deny_cnt_bus); else passes++;
      @(posedge clk);
      #1;
      checks++; if (entry_grant !== 1'b0) $display("FAIL rstmid_no_grant: got %b want 0", entry_grant); else passes++;
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
               ($urandom_range(0, 15) == 0), $urandom_range(0, 3), $urandom_range(0, 12),
               $urandom_range(0, 1));
         checks++; if ({entry_grant, entry_deny, exit_ack, exit_err} !== {e_grant, e_deny, e_ack, e_err})
            $display("FAIL rand_pulses[%0d]: got %b want %b", i,
                     {entry_grant, entry_deny, exit_ack, exit_err}, {e_grant, e_deny, e_ack, e_err});
         else passes++;
         checks++; if (occ_bus !== exp_occ_bus())
            $display("FAIL rand_occ[%0d]: got %0h want %0h", i, occ_bus, exp_occ_bus()); else passes++;
         checks++; if (free_bus !== exp_free_bus())
            $display("FAIL rand_free[%0d]: got %0h want %0h", i, free_bus, exp_free_bus()); else passes++;
         checks++; if (avail !== exp_avail())
            $display("FAIL rand_avail[%0d]: got %b want %b", i, avail, exp_avail()); else passes++;
         checks++; if ({total_occ, lot_full, phase} !== {10'(m_total()), m_total() == TOTAL, 3'(m_phase)})
            $display("FAIL rand_total_phase[%0d]: got %0d/%b/%0d want %0d/%b/%0d", i, total_occ, lot_full,
                     phase, m_total(), m_total() == TOTAL, m_phase);
         else passes++;
         checks++; if (deny_cnt_bus !== exp_deny_bus())
            $display("FAIL rand_deny[%0d]: got %0h want %0h", i, deny_cnt_bus, exp_deny_bus()); else passes++;
      end
   endtask

   initial begin
      reset = 1;
      idle_inputs();
      model_reset();
      test_reset();
      test_fill();
      test_phase();
      test_lot_full();
      test_concurrent();
      test_cap_lower();
      test_stats();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
